// File: rtl/fir_filter_mac_if.sv
// Bus bundle for the time-multiplexed FIR: sample handshake,
// coefficient write port and filtered-sample output.
interface fir_filter_mac_if #(
    parameter int NUM_TAPS       = 51,
    parameter int DATA_IN_WIDTH  = 16,
    parameter int TAP_DATA_WIDTH = 16,
    parameter int DATA_OUT_WIDTH = 24,
    parameter int ADDR_WIDTH     = $clog2(NUM_TAPS)
);
    logic signed [DATA_IN_WIDTH-1:0]  i_fir_data_in;
    logic                             i_fir_valid;
    logic                             o_fir_ready;
    logic                             i_coef_wr;
    logic [ADDR_WIDTH-1:0]            i_coef_addr;
    logic signed [TAP_DATA_WIDTH-1:0] i_coef_data;
    logic                             o_coef_drop;
    logic signed [DATA_OUT_WIDTH-1:0] o_fir_data_out;
    logic                             o_fir_valid;
    logic                             o_fir_sat;

    modport master (
        output i_fir_data_in, i_fir_valid,
        output i_coef_wr, i_coef_addr, i_coef_data,
        input  o_fir_ready, o_coef_drop,
        input  o_fir_data_out, o_fir_valid, o_fir_sat
    );

    modport slave (
        input  i_fir_data_in, i_fir_valid,
        input  i_coef_wr, i_coef_addr, i_coef_data,
        output o_fir_ready, o_coef_drop,
        output o_fir_data_out, o_fir_valid, o_fir_sat
    );
endinterface

// File: rtl/fir_filter_mac.sv
// Time-multiplexed FIR: one signed MAC reused over NUM_TAPS cycles
// per sample, loadable taps, rounded/shifted/saturated output.
module fir_filter_mac #(
    parameter int NUM_TAPS       = 51,
    parameter int DATA_IN_WIDTH  = 16,
    parameter int TAP_DATA_WIDTH = 16,
    parameter int DATA_OUT_WIDTH = 24,
    parameter int OUT_SHIFT      = 8,
    parameter int ADDR_WIDTH     = $clog2(NUM_TAPS)
) (
    input logic             i_clk,
    input logic             i_rst,
    fir_filter_mac_if.slave bus
);
    localparam int PROD_W = DATA_IN_WIDTH + TAP_DATA_WIDTH;
    localparam int ACC_W  = PROD_W + $clog2(NUM_TAPS);
    localparam int EXT_W  = ACC_W - DATA_OUT_WIDTH + 2;

    localparam logic [ADDR_WIDTH:0]   TAPS = (ADDR_WIDTH+1)'(NUM_TAPS);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NUM_TAPS - 1);
    localparam logic [ADDR_WIDTH-1:0] WRAP = ADDR_WIDTH'(NUM_TAPS);
    localparam logic signed [ACC_W:0] ROUND =
        (ACC_W+1)'((64'd1 << OUT_SHIFT) >> 1);

    localparam logic signed [DATA_OUT_WIDTH-1:0] OUT_MAX =
        {1'b0, {(DATA_OUT_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_OUT_WIDTH-1:0] OUT_MIN =
        {1'b1, {(DATA_OUT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                           state;
    logic signed [DATA_IN_WIDTH-1:0]  samples [NUM_TAPS];
    logic signed [TAP_DATA_WIDTH-1:0] coefs [NUM_TAPS];
    logic [ADDR_WIDTH-1:0]            wptr;
    logic [ADDR_WIDTH-1:0]            newest;
    logic [ADDR_WIDTH-1:0]            k;
    logic [ADDR_WIDTH-1:0]            rd_idx;
    logic signed [ACC_W-1:0]          acc;
    logic signed [PROD_W-1:0]         prod;
    logic signed [ACC_W:0]            rounded;
    logic signed [ACC_W:0]            shifted;
    logic                             over;
    logic signed [DATA_OUT_WIDTH-1:0] clipped;
    logic                             coef_ok;

    // Tap read index walks backwards from the newest sample, modulo the
    // line length; the mod-2^ADDR_WIDTH arithmetic folds the wrap in.
    always_comb begin
        rd_idx = newest - k;
        if (newest < k) begin
            rd_idx = newest - k + WRAP;
        end
    end

    // Shared multiplier plus output rounding, shift and clip detection.
    always_comb begin
        prod    = coefs[k] * samples[rd_idx];
        rounded = (ACC_W+1)'(acc) + ROUND;
        shifted = rounded >>> OUT_SHIFT;
        over    = shifted[ACC_W:DATA_OUT_WIDTH-1]
                  != {EXT_W{shifted[DATA_OUT_WIDTH-1]}};
        clipped = shifted[DATA_OUT_WIDTH-1:0];
        if (over) begin
            clipped = shifted[ACC_W] ? OUT_MIN : OUT_MAX;
        end
    end

    // Coefficient writes only land while idle and in range.
    always_comb begin
        coef_ok = bus.i_coef_wr && (state == IDLE)
                  && ({1'b0, bus.i_coef_addr} < TAPS);
    end

    // Control FSM, delay line, coefficient store and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state              <= IDLE;
            bus.o_fir_ready    <= 1'b1;
            bus.o_fir_valid    <= 1'b0;
            bus.o_fir_sat      <= 1'b0;
            bus.o_fir_data_out <= '0;
            bus.o_coef_drop    <= 1'b0;
            acc                <= '0;
            wptr               <= '0;
            newest             <= '0;
            k                  <= '0;
            for (int i = 0; i < NUM_TAPS; i++) begin
                samples[i] <= '0;
                coefs[i]   <= '0;
            end
        end else begin
            bus.o_fir_valid <= 1'b0;
            if (bus.i_coef_wr && !coef_ok) begin
                bus.o_coef_drop <= 1'b1;
            end
            if (coef_ok) begin
                coefs[bus.i_coef_addr] <= bus.i_coef_data;
            end
            unique case (state)
                IDLE: begin
                    if (bus.i_fir_valid) begin
                        samples[wptr]   <= bus.i_fir_data_in;
                        newest          <= wptr;
                        wptr            <= (wptr == LAST) ? '0 : wptr + 1'b1;
                        acc             <= '0;
                        k               <= '0;
                        state           <= MAC;
                        bus.o_fir_ready <= 1'b0;
                    end
                end
                MAC: begin
                    acc <= acc + ACC_W'(prod);
                    if (k == LAST) begin
                        state <= OUT;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                OUT: begin
                    bus.o_fir_data_out <= clipped;
                    bus.o_fir_sat      <= over;
                    bus.o_fir_valid    <= 1'b1;
                    bus.o_fir_ready    <= 1'b1;
                    state              <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fir_filter_mac.sv
// Directed bench for fir_filter_mac: unshifted and OUT_SHIFT=8
// instances, impulse response, clipping, rounding, drops, reset.
module tb_fir_filter_mac;
    localparam int N = 51;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fir_filter_mac_if #(.NUM_TAPS(N)) bus0 ();
    fir_filter_mac_if #(.NUM_TAPS(N)) bus8 ();

    fir_filter_mac #(.NUM_TAPS(N), .OUT_SHIFT(0)) dut0 (
        .i_clk(clk), .i_rst(rst), .bus(bus0.slave)
    );

    fir_filter_mac #(.NUM_TAPS(N), .OUT_SHIFT(8)) dut8 (
        .i_clk(clk), .i_rst(rst), .bus(bus8.slave)
    );

    int     vectors = 0;
    int     errs = 0;
    int     ctab [N];
    longint mc [N];
    longint mx [N];

    task automatic check(input string tag,
                         input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus0.i_fir_valid   = 1'b0;
        bus0.i_fir_data_in = '0;
        bus0.i_coef_wr     = 1'b0;
        bus0.i_coef_addr   = '0;
        bus0.i_coef_data   = '0;
        bus8.i_fir_valid   = 1'b0;
        bus8.i_fir_data_in = '0;
        bus8.i_coef_wr     = 1'b0;
        bus8.i_coef_addr   = '0;
        bus8.i_coef_data   = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            mc[i] = 0;
            mx[i] = 0;
        end
    endtask

    function automatic void push(input longint x);
        for (int i = N - 1; i > 0; i--) mx[i] = mx[i-1];
        mx[0] = x;
    endfunction

    function automatic void model_out(output longint y, output logic s);
        longint a = 0;
        for (int i = 0; i < N; i++) a += mc[i] * mx[i];
        s = 1'b1;
        if (a > 8388607) y = 8388607;
        else if (a < -8388608) y = -8388608;
        else begin
            y = a;
            s = 1'b0;
        end
    endfunction

    task automatic wr0(input int a, input int d);
        bus0.i_coef_wr   = 1'b1;
        bus0.i_coef_addr = 6'(a);
        bus0.i_coef_data = 16'(d);
        @(posedge clk);
        @(negedge clk);
        bus0.i_coef_wr = 1'b0;
    endtask

    task automatic wr8(input int a, input int d);
        bus8.i_coef_wr   = 1'b1;
        bus8.i_coef_addr = 6'(a);
        bus8.i_coef_data = 16'(d);
        @(posedge clk);
        @(negedge clk);
        bus8.i_coef_wr = 1'b0;
    endtask

    task automatic wait_out0(output logic signed [23:0] y,
                             output logic s, output int lat);
        lat = 0;
        while (!bus0.o_fir_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("out0_timeout", bus0.o_fir_valid, 1);
        y = bus0.o_fir_data_out;
        s = bus0.o_fir_sat;
    endtask

    task automatic send0(input int x, output logic signed [23:0] y,
                         output logic s, output int lat);
        int c = 0;
        while (!bus0.o_fir_ready && c < 200) begin
            @(negedge clk);
            c++;
        end
        bus0.i_fir_valid   = 1'b1;
        bus0.i_fir_data_in = 16'(x);
        @(posedge clk);
        @(negedge clk);
        bus0.i_fir_valid = 1'b0;
        push(longint'(x));
        wait_out0(y, s, lat);
    endtask

    task automatic send8(input int x, output logic signed [23:0] y,
                         output logic s);
        int c = 0;
        while (!bus8.o_fir_ready && c < 200) begin
            @(negedge clk);
            c++;
        end
        bus8.i_fir_valid   = 1'b1;
        bus8.i_fir_data_in = 16'(x);
        @(posedge clk);
        @(negedge clk);
        bus8.i_fir_valid = 1'b0;
        c = 0;
        while (!bus8.o_fir_valid && c < 200) begin
            @(negedge clk);
            c++;
        end
        check("out8_timeout", bus8.o_fir_valid, 1);
        y = bus8.o_fir_data_out;
        s = bus8.o_fir_sat;
    endtask

    initial begin
        int half [26] = '{-3, -21, -12, 17, 40, 15, -45, -80, -20, 95,
                          150, 30, -170, -260, -45, 290, 430, 60, -480,
                          -720, -75, 850, 1350, 90, -2000, 5215};
        int sq [6] = '{100, -200, 3000, -1, 0, 32767};
        logic signed [23:0] y;
        logic s;
        int lat;
        int cnt;

        for (int i = 0; i < N; i++) begin
            ctab[i] = (i <= 25) ? half[i] : half[50 - i];
        end

        // Reset state and quiet idle
        do_reset();
        check("rst_ready", bus0.o_fir_ready, 1);
        check("rst_valid", bus0.o_fir_valid, 0);
        check("rst_data", bus0.o_fir_data_out, 0);
        check("rst_drop", bus0.o_coef_drop, 0);
        check("rst_sat", bus0.o_fir_sat, 0);
        cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus0.o_fir_valid) cnt++;
        end
        check("idle_no_valid", cnt, 0);

        // Impulse response reproduces the taps in order
        for (int i = 0; i < N; i++) begin
            wr0(i, ctab[i]);
            mc[i] = ctab[i];
        end
        for (int j = 0; j < N; j++) begin
            send0((j == 0) ? 1 : 0, y, s, lat);
            check($sformatf("imp_y%0d", j), y, ctab[j]);
            check($sformatf("imp_lat%0d", j), lat, 52);
            if (j == 25) check("imp_sat25", s, 0);
        end

        // Valid held high: one accept per 53 cycles, checked vs model
        begin
            longint expq [$];
            logic   satq [$];
            longint ey;
            logic   es;
            int     idx = 0;
            int     got = 0;
            int     cyc = 0;
            int     last_acc = -1;
            logic   pend;

            bus0.i_fir_valid   = 1'b1;
            bus0.i_fir_data_in = 16'(sq[0]);
            pend = bus0.o_fir_ready;
            if (pend) begin
                push(longint'(sq[0]));
                model_out(ey, es);
                expq.push_back(ey);
                satq.push_back(es);
                last_acc = 0;
            end
            while ((idx < 6 || got < 6) && cyc < 600) begin
                @(negedge clk);
                cyc++;
                if (pend) begin
                    idx++;
                    if (idx < 6) bus0.i_fir_data_in = 16'(sq[idx]);
                    else bus0.i_fir_valid = 1'b0;
                end
                if (bus0.o_fir_valid) begin
                    if (expq.size() > 0) begin
                        check($sformatf("cont_y%0d", got),
                              bus0.o_fir_data_out, expq.pop_front());
                        check($sformatf("cont_sat%0d", got),
                              bus0.o_fir_sat, satq.pop_front());
                    end else begin
                        check("cont_spurious", 1, 0);
                    end
                    got++;
                end
                if (last_acc >= 0 && cyc == last_acc + 2) begin
                    check("cont_busy", bus0.o_fir_ready, 0);
                end
                pend = bus0.o_fir_ready && bus0.i_fir_valid;
                if (pend) begin
                    push(longint'(sq[idx]));
                    model_out(ey, es);
                    expq.push_back(ey);
                    satq.push_back(es);
                    if (last_acc >= 0) check("cont_spacing", cyc - last_acc, 53);
                    last_acc = cyc;
                end
            end
            bus0.i_fir_valid = 1'b0;
            check("cont_count", got, 6);
        end

        // Positive and negative clipping with all taps at full scale
        do_reset();
        for (int i = 0; i < N; i++) wr0(i, 32767);
        send0(32767, y, s, lat);
        check("sat_pos_y", y, 8388607);
        check("sat_pos_flag", s, 1);
        do_reset();
        for (int i = 0; i < N; i++) wr0(i, 32767);
        send0(-32768, y, s, lat);
        check("sat_neg_y", y, -8388608);
        check("sat_neg_flag", s, 1);

        // Round-half-up with OUT_SHIFT=8
        do_reset();
        wr8(0, 1);
        send8(384, y, s);
        check("rnd_384", y, 2);
        check("rnd_384_sat", s, 0);
        send8(-384, y, s);
        check("rnd_m384", y, -1);
        send8(383, y, s);
        check("rnd_383", y, 1);
        send8(-385, y, s);
        check("rnd_m385", y, -2);

        // Coefficient write during MAC is dropped and sticky
        do_reset();
        check("drop_clear", bus0.o_coef_drop, 0);
        wr0(0, 5);
        bus0.i_fir_valid   = 1'b1;
        bus0.i_fir_data_in = 16'(10);
        @(posedge clk);
        @(negedge clk);
        bus0.i_fir_valid = 1'b0;
        repeat (3) @(negedge clk);
        wr0(0, 100);
        check("drop_mac", bus0.o_coef_drop, 1);
        wait_out0(y, s, lat);
        check("drop_mac_y", y, 50);
        send0(1, y, s, lat);
        check("drop_keep_coef", y, 5);
        check("drop_sticky", bus0.o_coef_drop, 1);

        // Out-of-range address, then write and accept on the same edge
        do_reset();
        check("drop_rst", bus0.o_coef_drop, 0);
        wr0(51, 9);
        check("drop_addr51", bus0.o_coef_drop, 1);
        bus0.i_coef_wr     = 1'b1;
        bus0.i_coef_addr   = 6'd0;
        bus0.i_coef_data   = 16'(7);
        bus0.i_fir_valid   = 1'b1;
        bus0.i_fir_data_in = 16'(3);
        @(posedge clk);
        @(negedge clk);
        bus0.i_coef_wr   = 1'b0;
        bus0.i_fir_valid = 1'b0;
        wait_out0(y, s, lat);
        check("same_edge_y", y, 21);
        check("same_edge_lat", lat, 52);

        // Reset in the middle of MAC aborts the sample
        bus0.i_fir_valid   = 1'b1;
        bus0.i_fir_data_in = 16'(1000);
        @(posedge clk);
        @(negedge clk);
        bus0.i_fir_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_busy", bus0.o_fir_ready, 0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort_ready", bus0.o_fir_ready, 1);
        check("abort_valid", bus0.o_fir_valid, 0);
        check("abort_data", bus0.o_fir_data_out, 0);
        check("abort_drop", bus0.o_coef_drop, 0);
        cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus0.o_fir_valid) cnt++;
        end
        check("abort_no_valid", cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
